// File: rtl/sine_pwm_dac.sv
// Decimating sine-to-PWM stage: latches one attenuated, offset-binary sample per PWM period
// and drives a 1-bit PWM pin for an external RC reconstruction filter.
//
// state | meaning
// IDLE  | stopped, counter parked at 0, pin low
// RUN   | PWM period in progress, enable high
// DRAIN | enable dropped mid-period, finishing the current period
module sine_pwm_dac #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk_1mhz,
    input  logic                reset,
    input  logic                enable,
    input  logic [15:0]         sample_in,
    input  logic [1:0]          gain_shift,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty_out,
    output logic                sample_strobe,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PWM_BITS-1:0] counter;
    logic signed [15:0]  scaled;
    logic [15:0]         offset;
    logic [PWM_BITS-1:0] duty_next;
    logic                tc;
    logic                load;
    logic                clear;
    logic                count_en;

    // Attenuate, flip the sign bit into offset binary, keep the top PWM_BITS bits.
    assign scaled    = $signed(sample_in) >>> gain_shift;
    assign offset    = scaled ^ 16'h8000;
    assign duty_next = offset[15 -: PWM_BITS];
    assign tc        = (counter == {PWM_BITS{1'b1}});

    always_ff @(posedge clk_1mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (enable) state_nxt = RUN;
            RUN, DRAIN: begin
                if (tc) state_nxt = enable ? RUN : IDLE;
                else    state_nxt = enable ? RUN : DRAIN;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        clear    = 1'b0;
        count_en = 1'b0;
        case (state)
            IDLE:       load = enable;
            RUN, DRAIN: begin
                if (tc) begin
                    load  = enable;
                    clear = ~enable;
                end else begin
                    count_en = 1'b1;
                end
            end
            default:    clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk_1mhz) begin
        if (reset) begin
            counter       <= '0;
            duty_out      <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= load;
            if (load) begin
                duty_out <= duty_next;
                counter  <= '0;
            end else if (clear) begin
                duty_out <= '0;
                counter  <= '0;
            end else if (count_en) begin
                counter <= counter + PWM_BITS'(1);
            end
        end
    end

    // Pin decode uses registers only, so input glitches never reach the filter.
    assign busy    = (state != IDLE);
    assign pwm_out = busy && (counter < duty_out);

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Scoreboarded bench for sine_pwm_dac: a period-position model predicts every output,
// and a monitor pops expected duties whenever the DUT strobes.
module tb_sine_pwm_dac;

    localparam int PWM_BITS = 8;
    localparam int PERIOD   = 1 << PWM_BITS;

    logic                clk_1mhz = 1'b0;
    logic                reset;
    logic                enable;
    logic [15:0]         sample_in;
    logic [1:0]          gain_shift;
    logic                pwm_out;
    logic [PWM_BITS-1:0] duty_out;
    logic                sample_strobe;
    logic                busy;

    sine_pwm_dac #(.PWM_BITS(PWM_BITS)) dut (
        .clk_1mhz      (clk_1mhz),
        .reset         (reset),
        .enable        (enable),
        .sample_in     (sample_in),
        .gain_shift    (gain_shift),
        .pwm_out       (pwm_out),
        .duty_out      (duty_out),
        .sample_strobe (sample_strobe),
        .busy          (busy)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model: position within the current period (-1 = stopped).
    int m_pos    = -1;
    int m_duty   = 0;
    bit m_strobe = 0;
    int exp_q[$];

    function automatic int conv(input logic [15:0] s, input logic [1:0] g);
        int v, d, sc;
        v  = int'($signed(s));
        d  = 1 << g;
        sc = (v >= 0) ? v / d : -((-v + d - 1) / d);
        return (sc + 32768) / (1 << (16 - PWM_BITS));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk_1mhz) begin
        m_strobe = 0;
        if (reset) begin
            m_pos  = -1;
            m_duty = 0;
            exp_q.delete();
        end else if (m_pos < 0 || m_pos == PERIOD - 1) begin
            if (enable) begin
                m_pos    = 0;
                m_duty   = conv(sample_in, gain_shift);
                m_strobe = 1;
                exp_q.push_back(m_duty);
            end else begin
                m_pos  = -1;
                m_duty = 0;
            end
        end else begin
            m_pos++;
        end
    end

    always @(negedge clk_1mhz) begin
        if (chk_en) begin
            chk("busy",   32'(busy),          32'(m_pos >= 0));
            chk("pwm",    32'(pwm_out),       32'(m_pos >= 0 && m_pos < m_duty));
            chk("duty",   32'(duty_out),      32'(m_duty));
            chk("strobe", 32'(sample_strobe), 32'(m_strobe));
        end
    end

    // Scoreboard monitor: one expected duty per DUT strobe.
    always @(negedge clk_1mhz) begin
        if (chk_en && sample_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", 32'(1), 32'(0));
            end else begin
                chk("sb_duty", 32'(duty_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_strobe(output bit ok);
        ok = 0;
        for (int i = 0; i < 2 * PERIOD + 8; i++) begin
            @(negedge clk_1mhz);
            if (sample_strobe === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("strobe_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_pos(input int p);
        bit ok = 0;
        for (int i = 0; i < 2 * PERIOD + 8; i++) begin
            @(negedge clk_1mhz);
            if (m_pos == p) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("pos_timeout", 32'(p), 32'(m_pos));
    endtask

    logic [15:0] d_smp [7] = '{16'h0000, 16'h3fff, 16'hc001, 16'h7fff, 16'h8000, 16'h3fff, 16'hc001};
    logic [1:0]  d_gn  [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3};
    int          d_dty [7] = '{128, 191, 64, 255, 0, 159, 120};

    initial begin
        bit          ok;
        logic [31:0] acc;
        real         ph;

        reset      = 1;
        enable     = 1;
        sample_in  = 16'h1234;
        gain_shift = 0;
        @(posedge clk_1mhz);
        chk_en = 1;
        repeat (5) @(negedge clk_1mhz);

        // Directed duty table; each new sample is presented mid-period.
        sample_in  = d_smp[0];
        gain_shift = d_gn[0];
        reset      = 0;
        for (int i = 0; i < 7; i++) begin
            wait_strobe(ok);
            chk($sformatf("duty_tbl%0d", i), 32'(duty_out), 32'(d_dty[i]));
            if (i < 6) begin
                sample_in  = d_smp[i + 1];
                gain_shift = d_gn[i + 1];
            end
        end

        // Drop enable mid-period: period completes, then idle.
        wait_pos(37);
        enable = 0;
        wait_pos(-1);
        chk("drain_idle_busy", 32'(busy), 32'(0));
        repeat (3) @(negedge clk_1mhz);
        enable = 1;
        wait_pos(37);
        enable = 0;
        wait_pos(100);
        enable = 1;
        wait_pos(PERIOD - 1);
        @(negedge clk_1mhz);
        chk("no_gap_strobe", 32'(sample_strobe), 32'(1));
        chk("no_gap_busy",   32'(busy),          32'(1));

        // Randomized inputs every cycle, occasional enable toggles and resets.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk_1mhz);
            sample_in  = 16'($urandom);
            gain_shift = 2'($urandom_range(0, 3));
            reset      = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
        end
        reset  = 0;
        enable = 1;

        // Sine feed from a phase accumulator at the DDS increment.
        acc = 0;
        for (int c = 0; c < 8 * PERIOD; c++) begin
            @(negedge clk_1mhz);
            acc        = acc + 32'h001e4000;
            ph         = 6.283185307179586 * real'(acc) / 4294967296.0;
            sample_in  = 16'($rtoi(32767.0 * $sin(ph)));
            gain_shift = 0;
        end

        // Reset mid-period clears everything on the next cycle.
        wait_pos(50);
        reset = 1;
        @(negedge clk_1mhz);
        chk("rst_pwm",    32'(pwm_out),       32'(0));
        chk("rst_duty",   32'(duty_out),      32'(0));
        chk("rst_busy",   32'(busy),          32'(0));
        chk("rst_strobe", 32'(sample_strobe), 32'(0));
        reset = 0;
        repeat (PERIOD + 20) @(negedge clk_1mhz);

        enable = 0;
        wait_pos(-1);
        repeat (3) @(negedge clk_1mhz);
        chk("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
